i2s_capture_writer: RTL and testbench



---
 rtl/i2s_capture_writer_if.sv | 30 +++
 rtl/i2s_capture_writer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_i2s_capture_writer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_capture_writer_if.sv
// ============================================================================
//  Module      : i2s_capture_writer_if
//  Description : SDRAM arbiter word-write port (request/acknowledge, 64-bit).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface i2s_capture_writer_if;
    logic        sdram_wr;
    logic [22:0] sdram_addr;
    logic [63:0] sdram_data;
    logic        sdram_ac;

    // Capture writer drives the request, arbiter answers with a one-cycle ack
    modport master (
        output sdram_wr,
        output sdram_addr,
        output sdram_data,
        input  sdram_ac
    );

    modport slave (
        input  sdram_wr,
        input  sdram_addr,
        input  sdram_data,
        output sdram_ac
    );
endinterface

`default_nettype wire

// File: rtl/i2s_capture_writer.sv
// ============================================================================
//  Module      : i2s_capture_writer
//  Description : I2S ADC capture (codec is bus master) into an SDRAM ring.
//                Deserialises stereo samples, packs two frames per 64-bit
//                word, double-buffers words and writes them through a
//                request/acknowledge port.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module i2s_capture_writer #(
    parameter logic [22:0] BASE_ADDR   = 23'h400000,
    parameter logic [22:0] DEPTH_WORDS = 23'h100000,
    parameter int          SAMPLE_BITS = 16
) (
    input  wire logic               Clk50,
    input  wire logic               reset_n,
    input  wire logic               enable,
    input  wire logic               LRClk,
    input  wire logic               SClk,
    input  wire logic               Din,
    i2s_capture_writer_if.master    sdram,
    output logic                    sample_valid,
    output logic [15:0]             left_sample,
    output logic [15:0]             right_sample,
    output logic                    overrun,
    output logic                    busy
);

    localparam logic [22:0] c_LAST_ADDR   = BASE_ADDR + DEPTH_WORDS - 23'd1;
    localparam logic [4:0]  c_SAMPLE_BITS = 5'(SAMPLE_BITS);

    typedef enum logic [0:0] {DS_HUNT, DS_CAPTURE} ds_state_t;
    typedef enum logic [0:0] {WR_IDLE, WR_REQ}     wr_state_t;

    // ------------------------------------------------------------------
    // Codec pin synchronisers and bit-clock edge detect
    // ------------------------------------------------------------------
    logic r_lrclk_meta, r_lrclk_sync;
    logic r_sclk_meta,  r_sclk_sync, r_sclk_prev;
    logic r_din_meta,   r_din_sync;
    logic w_tick;

    // Two-flop synchronisers plus a delayed SClk copy for edge detection
    always_ff @(posedge Clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_lrclk_meta <= 1'b0;
            r_lrclk_sync <= 1'b0;
            r_sclk_meta  <= 1'b0;
            r_sclk_sync  <= 1'b0;
            r_sclk_prev  <= 1'b0;
            r_din_meta   <= 1'b0;
            r_din_sync   <= 1'b0;
        end else begin
            r_lrclk_meta <= LRClk;
            r_lrclk_sync <= r_lrclk_meta;
            r_sclk_meta  <= SClk;
            r_sclk_sync  <= r_sclk_meta;
            r_sclk_prev  <= r_sclk_sync;
            r_din_meta   <= Din;
            r_din_sync   <= r_din_meta;
        end
    end

    assign w_tick = r_sclk_sync & ~r_sclk_prev;

    // ------------------------------------------------------------------
    // Deserialiser
    // ------------------------------------------------------------------
    ds_state_t              r_ds_state, w_ds_state_nxt;
    logic                   r_lr_prev;
    logic [4:0]             r_bitcnt;
    logic [4:0]             w_bitcnt_nxt;
    logic [SAMPLE_BITS-1:0] r_shift;
    logic [SAMPLE_BITS-1:0] w_shift_nxt;
    logic [15:0]            w_sample16;
    logic                   w_cap_tick, w_shift_en, w_latch, w_frame_done;
    logic [15:0]            r_left_hold;

    // Deserialiser state register
    always_ff @(posedge Clk50 or negedge reset_n) begin
        if (!reset_n) r_ds_state <= DS_HUNT;
        else          r_ds_state <= w_ds_state_nxt;
    end

    // Hunt for the left-slot start (sampled LRClk 1->0); enable low forces a re-hunt
    always_comb begin
        w_ds_state_nxt = r_ds_state;
        if (!enable) begin
            w_ds_state_nxt = DS_HUNT;
        end else if (w_tick && (r_ds_state == DS_HUNT) && r_lr_prev && !r_lrclk_sync) begin
            w_ds_state_nxt = DS_CAPTURE;
        end
    end

    // The tick where LRClk changes is the I2S delay bit, so the count restarts at 0
    assign w_bitcnt_nxt = (r_lrclk_sync != r_lr_prev) ? 5'd0 :
                          (r_bitcnt == 5'd31)         ? 5'd31 : r_bitcnt + 5'd1;
    assign w_cap_tick   = w_tick && enable && (r_ds_state == DS_CAPTURE);
    assign w_shift_en   = w_cap_tick && (w_bitcnt_nxt != 5'd0) && (w_bitcnt_nxt <= c_SAMPLE_BITS);
    assign w_latch      = w_cap_tick && (w_bitcnt_nxt == c_SAMPLE_BITS);
    assign w_frame_done = w_latch && r_lrclk_sync;
    assign w_shift_nxt  = SAMPLE_BITS'({r_shift, r_din_sync});

    // Samples are left-justified in a 16-bit field
    generate
        if (SAMPLE_BITS >= 16) begin : g_wide_sample
            assign w_sample16 = w_shift_nxt[SAMPLE_BITS-1 -: 16];
        end else begin : g_narrow_sample
            assign w_sample16 = {w_shift_nxt, {(16-SAMPLE_BITS){1'b0}}};
        end
    endgenerate

    // Bit counter, LRClk history and channel shift register
    always_ff @(posedge Clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_lr_prev <= 1'b0;
            r_bitcnt  <= 5'd0;
            r_shift   <= '0;
        end else begin
            if (w_tick) r_lr_prev <= r_lrclk_sync;
            if (w_cap_tick)
                r_bitcnt <= w_bitcnt_nxt;
            else if (w_ds_state_nxt == DS_CAPTURE && r_ds_state == DS_HUNT)
                r_bitcnt <= 5'd0;
            if (w_shift_en) r_shift <= w_shift_nxt;
        end
    end

    // Sample latches and the per-frame monitor outputs
    always_ff @(posedge Clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_left_hold  <= 16'd0;
            left_sample  <= 16'd0;
            right_sample <= 16'd0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (w_latch && !r_lrclk_sync) r_left_hold <= w_sample16;
            if (w_frame_done) begin
                left_sample  <= r_left_hold;
                right_sample <= w_sample16;
                sample_valid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame packer: frame 0 in the low half, frame 1 completes the word
    // ------------------------------------------------------------------
    logic        r_pack_idx;
    logic [31:0] r_pack_lo;
    logic        w_word_done;
    logic [63:0] w_word;

    assign w_word_done = w_frame_done && r_pack_idx;
    assign w_word      = {w_sample16, r_left_hold, r_pack_lo};

    // Collect the first frame of a word; disabling discards a half word
    always_ff @(posedge Clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_pack_idx <= 1'b0;
            r_pack_lo  <= 32'd0;
        end else if (!enable) begin
            r_pack_idx <= 1'b0;
            r_pack_lo  <= 32'd0;
        end else if (w_frame_done) begin
            if (!r_pack_idx) r_pack_lo <= {w_sample16, r_left_hold};
            r_pack_idx <= ~r_pack_idx;
        end
    end

    // ------------------------------------------------------------------
    // Two-entry word buffer and write handshake
    // ------------------------------------------------------------------
    wr_state_t   r_wr_state, w_wr_state_nxt;
    logic        r_full_a, r_full_b, r_oldest_b, r_sel_b;
    logic [63:0] r_data_a, r_data_b;
    logic [63:0] r_wdata;
    logic [22:0] r_addr;
    logic        w_load, w_ack_done, w_pick_b, w_keep_a, w_keep_b;

    // Serve B only when it is the sole full entry or the older of two
    assign w_pick_b = r_full_b && (!r_full_a || r_oldest_b);
    // An entry being acknowledged this cycle already counts as free
    assign w_keep_a = r_full_a && !(w_ack_done && !r_sel_b);
    assign w_keep_b = r_full_b && !(w_ack_done &&  r_sel_b);

    // Write FSM state register
    always_ff @(posedge Clk50 or negedge reset_n) begin
        if (!reset_n) r_wr_state <= WR_IDLE;
        else          r_wr_state <= w_wr_state_nxt;
    end

    // Issue a request for the oldest full entry; finish on acknowledge
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_load         = 1'b0;
        w_ack_done     = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                if (r_full_a || r_full_b) begin
                    w_wr_state_nxt = WR_REQ;
                    w_load         = 1'b1;
                end
            end
            WR_REQ: begin
                if (sdram.sdram_ac) begin
                    w_wr_state_nxt = WR_IDLE;
                    w_ack_done     = 1'b1;
                end
            end
            default: w_wr_state_nxt = WR_IDLE;
        endcase
    end

    // Buffer entries, age tracking, overrun flag, request data and ring address
    always_ff @(posedge Clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_full_a   <= 1'b0;
            r_full_b   <= 1'b0;
            r_oldest_b <= 1'b0;
            r_sel_b    <= 1'b0;
            r_data_a   <= 64'd0;
            r_data_b   <= 64'd0;
            r_wdata    <= 64'd0;
            r_addr     <= BASE_ADDR;
            overrun    <= 1'b0;
        end else begin
            if (w_load) begin
                r_wdata <= w_pick_b ? r_data_b : r_data_a;
                r_sel_b <= w_pick_b;
            end
            if (w_ack_done) begin
                if (r_sel_b) begin
                    r_full_b   <= 1'b0;
                    r_oldest_b <= 1'b0;
                end else begin
                    r_full_a   <= 1'b0;
                    r_oldest_b <= 1'b1;
                end
                r_addr <= (r_addr == c_LAST_ADDR) ? BASE_ADDR : r_addr + 23'd1;
            end
            if (w_word_done) begin
                if (!w_keep_a) begin
                    r_full_a   <= 1'b1;
                    r_data_a   <= w_word;
                    r_oldest_b <= w_keep_b;
                end else if (!w_keep_b) begin
                    r_full_b   <= 1'b1;
                    r_data_b   <= w_word;
                    r_oldest_b <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

    assign sdram.sdram_wr   = (r_wr_state == WR_REQ);
    assign sdram.sdram_addr = r_addr;
    assign sdram.sdram_data = r_wdata;
    assign busy             = r_full_a | r_full_b | (r_wr_state == WR_REQ);

endmodule

`default_nettype wire

// File: tb/tb_i2s_capture_writer.sv
// ============================================================================
//  Module      : tb_i2s_capture_writer
//  Description : Directed self-checking bench for i2s_capture_writer.
//                A second instance with a two-word ring shares the stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_i2s_capture_writer;

    logic        clk = 1'b0;
    logic        reset_n, enable, LRClk, SClk, Din;
    logic        sv1, sv2, ovr1, ovr2, busy1, busy2;
    logic [15:0] left1, right1, left2, right2;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          sv_cnt   = 0;
    logic        ack_en   = 1'b1;
    logic [22:0] log1_addr[$];
    logic [63:0] log1_data[$];
    logic [22:0] log2_addr[$];

    i2s_capture_writer_if bus1 ();
    i2s_capture_writer_if bus2 ();

    i2s_capture_writer dut (
        .Clk50(clk), .reset_n(reset_n), .enable(enable), .LRClk(LRClk), .SClk(SClk),
        .Din(Din), .sdram(bus1), .sample_valid(sv1), .left_sample(left1),
        .right_sample(right1), .overrun(ovr1), .busy(busy1)
    );

    i2s_capture_writer #(.DEPTH_WORDS(23'd2)) dut_ring2 (
        .Clk50(clk), .reset_n(reset_n), .enable(enable), .LRClk(LRClk), .SClk(SClk),
        .Din(Din), .sdram(bus2), .sample_valid(sv2), .left_sample(left2),
        .right_sample(right2), .overrun(ovr2), .busy(busy2)
    );

    always #10 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Arbiter model for the main instance: ack five cycles into a request
    initial begin
        int wcnt;
        wcnt = 0;
        bus1.sdram_ac = 1'b0;
        forever begin
            @(negedge clk);
            if (bus1.sdram_ac) begin
                bus1.sdram_ac = 1'b0;
            end else if (ack_en && bus1.sdram_wr) begin
                if (wcnt >= 4) begin
                    bus1.sdram_ac = 1'b1;
                    log1_addr.push_back(bus1.sdram_addr);
                    log1_data.push_back(bus1.sdram_data);
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Arbiter model for the ring-of-two instance: ack on the first cycle seen
    initial begin
        bus2.sdram_ac = 1'b0;
        forever begin
            @(negedge clk);
            if (bus2.sdram_ac) begin
                bus2.sdram_ac = 1'b0;
            end else if (bus2.sdram_wr) begin
                bus2.sdram_ac = 1'b1;
                log2_addr.push_back(bus2.sdram_addr);
            end
        end
    end

    // Frame pulse counter
    initial begin
        forever begin
            @(negedge clk);
            if (sv1) sv_cnt++;
        end
    end

    // One SClk period (Clk50/16); data and word select change on the falling edge
    task automatic sbit(input logic lr, input logic d);
        LRClk = lr;
        Din   = d;
        #160 SClk = 1'b1;
        #160 SClk = 1'b0;
    endtask

    // 32-bit slot: delay bit, 16 data bits MSB first, zero padding
    task automatic send_slot(input logic lr, input logic [15:0] v);
        for (int i = 0; i < 32; i++) begin
            if (i >= 1 && i <= 16) sbit(lr, v[16-i]);
            else                   sbit(lr, 1'b0);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_slot(1'b0, l);
        send_slot(1'b1, r);
    endtask

    task automatic wait_logs(input int n1, input int n2);
        int k;
        k = 0;
        while ((log1_addr.size() < n1 || log2_addr.size() < n2) && k < 500) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        LRClk   = 1'b0;
        SClk    = 1'b0;
        Din     = 1'b0;
        repeat (5) @(negedge clk);

        // Reset state
        check_value("rst_wr",    bus1.sdram_wr,   1'b0);
        check_value("rst_addr",  bus1.sdram_addr, 23'h400000);
        check_value("rst_data",  bus1.sdram_data, 64'd0);
        check_value("rst_valid", sv1,             1'b0);
        check_value("rst_left",  left1,           16'd0);
        check_value("rst_right", right1,          16'd0);
        check_value("rst_ovr",   ovr1,            1'b0);
        check_value("rst_busy",  busy1,           1'b0);

        // Mid-frame start then normal capture: garbage ignored until LRClk 1->0
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) sbit(1'b0, 1'b1);
        send_slot(1'b1, 16'hFFFF);
        check_value("hunt_valid_cnt", sv_cnt, 0);
        send_frame(16'h1234, 16'hABCD);
        send_frame(16'h5678, 16'hEF01);
        wait_logs(1, 1);
        check_value("norm_nwrites", log1_addr.size(), 1);
        check_value("norm_addr",    log1_addr[0],     23'h400000);
        check_value("norm_data",    log1_data[0],     64'hEF01_5678_ABCD_1234);
        check_value("norm_valids",  sv_cnt,           2);
        check_value("norm_left",    left1,            16'h5678);
        check_value("norm_right",   right1,           16'hEF01);
        check_value("norm_ovr",     ovr1,             1'b0);

        // Ring wrap on the two-word instance, linear progress on the main one
        send_frame(16'h1111, 16'h2222);
        send_frame(16'h3333, 16'h4444);
        send_frame(16'h5555, 16'h6666);
        send_frame(16'h7777, 16'h8888);
        send_frame(16'h9999, 16'hAAAA);
        send_frame(16'hBBBB, 16'hCCCC);
        wait_logs(4, 4);
        check_value("wrap_n1",   log1_addr.size(), 4);
        check_value("wrap_n2",   log2_addr.size(), 4);
        check_value("wrap_a2_1", log2_addr[1], 23'h400001);
        check_value("wrap_a2_2", log2_addr[2], 23'h400000);
        check_value("wrap_a2_3", log2_addr[3], 23'h400001);
        check_value("lin_a1_3",  log1_addr[3], 23'h400003);
        check_value("lin_d1_1",  log1_data[1], 64'h4444_3333_2222_1111);
        check_value("lin_d1_2",  log1_data[2], 64'h8888_7777_6666_5555);
        check_value("lin_d1_3",  log1_data[3], 64'hCCCC_BBBB_AAAA_9999);

        // Overrun: no acks for three words
        do_reset();
        log1_addr.delete();
        log1_data.delete();
        ack_en = 1'b0;
        for (int i = 0; i < 4; i++) sbit(1'b1, 1'b0);
        send_frame(16'h0001, 16'h0002);
        send_frame(16'h0003, 16'h0004);
        send_frame(16'h0005, 16'h0006);
        send_frame(16'h0007, 16'h0008);
        send_frame(16'h0009, 16'h000A);
        send_frame(16'h000B, 16'h000C);
        check_value("ovr_flag",  ovr1,             1'b1);
        check_value("ovr_busy",  busy1,            1'b1);
        check_value("ovr_wr",    bus1.sdram_wr,    1'b1);
        check_value("ovr_addr",  bus1.sdram_addr,  23'h400000);
        check_value("ovr_nlog",  log1_addr.size(), 0);
        ack_en = 1'b1;
        wait_logs(2, 0);
        check_value("ovr_a0",     log1_addr[0], 23'h400000);
        check_value("ovr_d0",     log1_data[0], 64'h0004_0003_0002_0001);
        check_value("ovr_a1",     log1_addr[1], 23'h400001);
        check_value("ovr_d1",     log1_data[1], 64'h0008_0007_0006_0005);
        repeat (4) @(negedge clk);
        check_value("ovr_next",   bus1.sdram_addr, 23'h400002);
        send_frame(16'h000D, 16'h000E);
        send_frame(16'h000F, 16'h0010);
        wait_logs(3, 0);
        check_value("ovr_a2",     log1_addr[2], 23'h400002);
        check_value("ovr_d2",     log1_data[2], 64'h0010_000F_000E_000D);
        check_value("ovr_sticky", ovr1,         1'b1);

        // Enable toggle discards the half word
        log1_addr.delete();
        log1_data.delete();
        sv_cnt = 0;
        send_frame(16'h1357, 16'h2468);
        enable = 1'b0;
        repeat (20) @(negedge clk);
        check_value("en_nlog", log1_addr.size(), 0);
        check_value("en_busy", busy1,            1'b0);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(16'h0A0A, 16'h0B0B);
        send_frame(16'h0C0C, 16'h0D0D);
        wait_logs(1, 0);
        check_value("en_nwrites", log1_addr.size(), 1);
        check_value("en_addr",    log1_addr[0],     23'h400003);
        check_value("en_data",    log1_data[0],     64'h0D0D_0C0C_0B0B_0A0A);
        check_value("en_valids",  sv_cnt,           3);

        // Asynchronous reset while a request is pending
        ack_en = 1'b0;
        send_frame(16'h0001, 16'h0002);
        send_frame(16'h0003, 16'h0004);
        begin
            int k;
            k = 0;
            while (!bus1.sdram_wr && k < 500) begin
                @(negedge clk);
                k++;
            end
        end
        check_value("ar_req_up", bus1.sdram_wr, 1'b1);
        @(negedge clk);
        #5 reset_n = 1'b0;
        #1;
        check_value("ar_wr",    bus1.sdram_wr,   1'b0);
        check_value("ar_addr",  bus1.sdram_addr, 23'h400000);
        check_value("ar_data",  bus1.sdram_data, 64'd0);
        check_value("ar_busy",  busy1,           1'b0);
        check_value("ar_ovr",   ovr1,            1'b0);
        check_value("ar_left",  left1,           16'd0);
        check_value("ar_right", right1,          16'd0);
        check_value("ar_valid", sv1,             1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
